// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and reads one- or two-word instructions
// from the shared memory port. It holds a complete instruction in DONE until
// control issues an INC/LOAD operation.
//
// state | meaning
// REQ0  | request first word at pc, wait for grant
// DATA0 | capture first word, decide instruction length
// REQ1  | request second word at pc+1, wait for grant
// DATA1 | capture second word into imm
// DONE  | instruction complete; wait for fetch_operation
module fetch_unit #(
    parameter int                     PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n_async,
    input  logic [1:0]                fetch_operation,
    input  logic [PC_WIDTH-1:0]       branch_target,
    output logic                      fetch_complete,
    output logic [PC_WIDTH-1:0]       pc,
    output logic [15:0]               inst,
    output logic [15:0]               imm,
    output logic                      mem_req,
    output logic [PC_WIDTH-1:0]       mem_addr,
    input  logic                      mem_ready,
    input  logic [15:0]               mem_rdata
);

    localparam logic [1:0] FETCH_NOP     = 2'b00;
    localparam logic [1:0] FETCH_INC_PC  = 2'b01;
    localparam logic [1:0] FETCH_LOAD_PC = 2'b10;

    typedef enum logic [2:0] {
        S_REQ0  = 3'd0,
        S_DATA0 = 3'd1,
        S_REQ1  = 3'd2,
        S_DATA1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]          inst_q, inst_d;
    logic [15:0]          imm_q, imm_d;
    logic                 fc_q, fc_d;
    logic [PC_WIDTH-1:0]  pc_step;

    // Instruction length comes from the captured first word, which is stable in DONE.
    assign pc_step = (inst_q[15:14] == 2'b11) ? PC_WIDTH'(2) : PC_WIDTH'(1);

    // Next-state, datapath capture and memory request decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        imm_d    = imm_q;
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state_q)
            S_REQ0: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) state_d = S_DATA0;
            end
            S_DATA0: begin
                inst_d  = mem_rdata;
                state_d = (mem_rdata[15:14] == 2'b11) ? S_REQ1 : S_DONE;
            end
            S_REQ1: begin
                mem_req  = 1'b1;
                mem_addr = pc_q + PC_WIDTH'(1);
                if (mem_ready) state_d = S_DATA1;
            end
            S_DATA1: begin
                imm_d   = mem_rdata;
                state_d = S_DONE;
            end
            S_DONE: begin
                case (fetch_operation)
                    FETCH_INC_PC: begin
                        pc_d    = pc_q + pc_step;
                        state_d = S_REQ0;
                    end
                    FETCH_LOAD_PC: begin
                        pc_d    = branch_target;
                        state_d = S_REQ0;
                    end
                    FETCH_NOP: state_d = S_DONE;
                    default:   state_d = S_DONE;
                endcase
            end
            default: state_d = S_REQ0;
        endcase
        // Registered completion flag tracks DONE exactly, so it is never high mid-fetch.
        fc_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            state_q <= S_REQ0;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            imm_q   <= '0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            imm_q   <= imm_d;
            fc_q    <= fc_d;
        end
    end

    assign fetch_complete = fc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign imm            = imm_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: sparse memory model, scheduled arbiter stalls,
// scoreboard of expected completed instructions checked by a separate monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  fetch_operation = 2'b00;
    logic [15:0] branch_target = '0;
    logic        fetch_complete;
    logic [15:0] pc, inst, imm;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_rdata = '0;

    fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst_n_async     (rst_n),
        .fetch_operation (fetch_operation),
        .branch_target   (branch_target),
        .fetch_complete  (fetch_complete),
        .pc              (pc),
        .inst            (inst),
        .imm             (imm),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] imm;
        int          start;
        int          lat;
    } exp_t;
    exp_t q[$];

    logic [15:0] mem [bit [15:0]];

    // reference model state
    logic [15:0] pc_m = '0;
    logic [15:0] inst_m = '0;
    logic [15:0] imm_m = '0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory: answer one cycle after an accepted request, garbage otherwise
    initial begin
        logic        acc;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            acc = mem_req && mem_ready;
            a   = mem_addr;
            @(posedge clk);
            #1;
            mem_rdata = acc ? rd(a) : 16'($urandom);
        end
    end

    // monitor: pop expected instruction on each rising fetch_complete
    initial begin
        logic fc_prev;
        exp_t e;
        fc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fc_prev = 1'b0;
            end else begin
                if (!mem_req) chk("addr_idle", 32'(mem_addr), 32'd0);
                if (fetch_complete && !fc_prev) begin
                    if (q.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_complete: got pc %h inst %h with no fetch outstanding", pc, inst);
                    end else begin
                        e = q.pop_front();
                        chk("done_pc",   32'(pc),   32'(e.pc));
                        chk("done_inst", 32'(inst), 32'(e.inst));
                        chk("done_imm",  32'(imm),  32'(e.imm));
                        chk("latency",   32'(cyc - e.start), 32'(e.lat));
                    end
                end
                fc_prev = fetch_complete;
            end
        end
    end

    // Called at the driving point of the first cycle in REQ0. abort_k >= 0 asserts reset then.
    task automatic start_fetch(input int s0, input int s1, input int abort_k);
        logic        two;
        logic [15:0] a1;
        int          lat;
        exp_t        e;
        inst_m = rd(pc_m);
        two    = (inst_m[15:14] == 2'b11);
        a1     = pc_m + 16'd1;
        if (two) imm_m = rd(a1);
        lat = two ? (s0 + s1 + 4) : (s0 + 2);
        e.pc = pc_m; e.inst = inst_m; e.imm = imm_m; e.start = cyc; e.lat = lat;
        if (abort_k < 0) q.push_back(e);
        for (int k = 0; k < lat; k++) begin
            if (k == abort_k) begin
                rst_n = 1'b0;
                return;
            end
            if (k < s0) mem_ready = 1'b0;
            else if (k == s0) mem_ready = 1'b1;
            else if (two && k >= s0 + 2 && k < s0 + 2 + s1) mem_ready = 1'b0;
            else if (two && k == s0 + 2 + s1) mem_ready = 1'b1;
            else mem_ready = 1'($urandom);
            fetch_operation = 2'($urandom);
            branch_target   = 16'($urandom);
            @(negedge clk);
            if (k == 0) begin
                chk("start_fc",    32'(fetch_complete), 32'd0);
                chk("start_req",   32'(mem_req),        32'd1);
                chk("start_addr",  32'(mem_addr),       32'(pc_m));
                chk("start_pc",    32'(pc),             32'(pc_m));
            end
            @(posedge clk);
            #1;
        end
        fetch_operation = 2'b00;
        mem_ready = 1'($urandom);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_operation = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            branch_target   = 16'($urandom);
            mem_ready       = 1'($urandom);
            @(negedge clk);
            chk("hold_fc",   32'(fetch_complete), 32'd1);
            chk("hold_req",  32'(mem_req),        32'd0);
            chk("hold_pc",   32'(pc),             32'(pc_m));
            chk("hold_inst", 32'(inst),           32'(inst_m));
            chk("hold_imm",  32'(imm),            32'(imm_m));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] target);
        if (op == 2'b10) pc_m = target;
        else pc_m = pc_m + ((inst_m[15:14] == 2'b11) ? 16'd2 : 16'd1);
        fetch_operation = op;
        branch_target   = target;
        @(posedge clk);
        #1;
        fetch_operation = 2'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        pc_m = 16'h0000; inst_m = '0; imm_m = '0;
        mem_ready = 1'($urandom);
        @(negedge clk);
        chk("rst_pc",   32'(pc),             32'd0);
        chk("rst_inst", 32'(inst),           32'd0);
        chk("rst_imm",  32'(imm),            32'd0);
        chk("rst_fc",   32'(fetch_complete), 32'd0);
        chk("rst_req",  32'(mem_req),        32'd1);
        chk("rst_addr", 32'(mem_addr),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        mem[16'h0000] = 16'hC001;
        mem[16'h0001] = 16'hBEEF;
        mem[16'h0002] = 16'h4123;
        mem[16'h0003] = 16'hC0DE;
        mem[16'hFFFF] = 16'hC000;

        // two-word fetch after reset, then INC to 2
        do_reset();
        start_fetch(0, 0, -1);
        hold(1);
        issue(2'b01, 16'h0000);
        // one-word fetch with a 3-cycle stall in REQ0, long hold
        start_fetch(3, 0, -1);
        hold(10);
        issue(2'b01, 16'h0000);
        // reset in the middle of REQ1 of a two-word fetch
        start_fetch(0, 0, 2);
        mem[16'h0000] = 16'h4123;
        do_reset();
        start_fetch(0, 0, -1);
        hold(2);
        // jump to top of memory; second word wraps to address 0
        issue(2'b10, 16'hFFFF);
        start_fetch(1, 2, -1);
        fetch_operation = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reserved_fc", 32'(fetch_complete), 32'd1);
            chk("reserved_pc", 32'(pc), 32'(pc_m));
            @(posedge clk);
            #1;
        end
        issue(2'b01, 16'h0000);
        start_fetch(0, 0, -1);
        hold(1);

        // randomized fetch stream
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) issue(2'b01, 16'($urandom));
            else issue(2'b10, 16'($urandom));
            s0 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            s1 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            start_fetch(s0, s1, -1);
            hold($urandom_range(0, 3));
        end
        hold(2);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
